// File: rtl/fpu_req_scheduler_if.sv
// Bundle of the requester, response and shared-FPU signals around fpu_req_scheduler.
// The scheduler takes the slave view; the core side and the FPU stub take the master view.
interface fpu_req_scheduler_if #(
  parameter int W   = 32,
  parameter int OPW = 4
);
  logic           req0_valid;
  logic           req0_ready;
  logic [W-1:0]   req0_num1;
  logic [W-1:0]   req0_num2;
  logic [OPW-1:0] req0_op;

  logic           req1_valid;
  logic           req1_ready;
  logic [W-1:0]   req1_num1;
  logic [W-1:0]   req1_num2;
  logic [OPW-1:0] req1_op;

  logic           rsp0_valid;
  logic           rsp0_ready;
  logic           rsp1_valid;
  logic           rsp1_ready;
  logic [W-1:0]   rsp_result;

  logic [W-1:0]   fpu_num1;
  logic [W-1:0]   fpu_num2;
  logic [OPW-1:0] fpu_op;
  logic [W-1:0]   fpu_result;

  logic           busy;
  logic           owner;

  modport slave (
    input  req0_valid, req0_num1, req0_num2, req0_op,
    input  req1_valid, req1_num1, req1_num2, req1_op,
    input  rsp0_ready, rsp1_ready, fpu_result,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result,
    output fpu_num1, fpu_num2, fpu_op, busy, owner
  );

  modport master (
    output req0_valid, req0_num1, req0_num2, req0_op,
    output req1_valid, req1_num1, req1_num2, req1_op,
    output rsp0_ready, rsp1_ready, fpu_result,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result,
    input  fpu_num1, fpu_num2, fpu_op, busy, owner
  );
endinterface

// File: rtl/fpu_req_scheduler.sv
// Two-requester round-robin scheduler in front of one combinational FPU: holds the operands
// for FPU_LAT cycles, captures the result and returns it to the owning requester.
module fpu_req_scheduler #(
  parameter int FPU_LAT = 2,
  parameter int W       = 32,
  parameter int OPW     = 4
) (
  input logic                clk,
  input logic                rst,
  fpu_req_scheduler_if.slave bus
);
  localparam int CW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [CW-1:0]  cnt_q;
  logic           last_grant_q;
  logic           owner_q;
  logic [W-1:0]   num1_q;
  logic [W-1:0]   num2_q;
  logic [OPW-1:0] op_q;
  logic [W-1:0]   result_q;

  logic           grant_vld;
  logic           grant_id;
  logic           exec_done;
  logic           rsp_take;
  logic [W-1:0]   win_num1;
  logic [W-1:0]   win_num2;
  logic [OPW-1:0] win_op;

  // Arbitration: only in IDLE; on a tie the requester that did not win last time goes first.
  always_comb begin
    // NOTE: every signal gets a default before the branches so no latch is inferred.
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (state_q == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = ~last_grant_q;
      end else if (bus.req0_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end else if (bus.req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign win_num1  = grant_id ? bus.req1_num1 : bus.req0_num1;
  assign win_num2  = grant_id ? bus.req1_num2 : bus.req0_num2;
  assign win_op    = grant_id ? bus.req1_op   : bus.req0_op;
  assign exec_done = (state_q == EXEC) && (cnt_q == '0);
  assign rsp_take  = (state_q == RESP) && (owner_q ? bus.rsp1_ready : bus.rsp0_ready);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_vld) state_d = EXEC;
      EXEC:    if (exec_done) state_d = RESP;
      RESP:    if (rsp_take)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: ready is a pure function of state and requester valids, never of rsp_ready.
  always_comb begin
    bus.req0_ready = grant_vld && !grant_id;
    bus.req1_ready = grant_vld &&  grant_id;
    bus.rsp0_valid = (state_q == RESP) && !owner_q;
    bus.rsp1_valid = (state_q == RESP) &&  owner_q;
    bus.rsp_result = result_q;
    bus.fpu_num1   = num1_q;
    bus.fpu_num2   = num2_q;
    bus.fpu_op     = op_q;
    bus.busy       = (state_q != IDLE);
    bus.owner      = owner_q;
  end

  // Datapath: operand bus, countdown, result capture and grant history.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      num1_q       <= '0;
      num2_q       <= '0;
      op_q         <= '0;
      result_q     <= '0;
    end else begin
      if (grant_vld) begin
        num1_q       <= win_num1;
        num2_q       <= win_num2;
        op_q         <= win_op;
        owner_q      <= grant_id;
        last_grant_q <= grant_id;
        cnt_q        <= CW'(FPU_LAT - 1);
      end
      if (state_q == EXEC && cnt_q != '0) cnt_q <= cnt_q - CW'(1);
      // The FPU is combinational; its output is trusted only after the full settle window.
      if (exec_done) result_q <= bus.fpu_result;
    end
  end
endmodule

// File: tb/tb_fpu_req_scheduler.sv
// Scoreboard bench for fpu_req_scheduler: one FPU_LAT=2 instance for the main scenarios and
// one FPU_LAT=1 instance for the minimum-latency case, both fed by a stub FPU.
module tb_fpu_req_scheduler;
  localparam int W   = 32;
  localparam int OPW = 4;

  typedef struct {
    logic [W-1:0] res;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpu_req_scheduler_if #(.W(W), .OPW(OPW)) a_if ();
  fpu_req_scheduler_if #(.W(W), .OPW(OPW)) b_if ();

  fpu_req_scheduler #(.FPU_LAT(2), .W(W), .OPW(OPW)) u_dut (.clk(clk), .rst(rst), .bus(a_if));
  fpu_req_scheduler #(.FPU_LAT(1), .W(W), .OPW(OPW)) u_dut1 (.clk(clk), .rst(rst), .bus(b_if));

  // Stub FPU: 15.0 for op 0, a recognisable operand mix for any other op.
  function automatic logic [W-1:0] stub(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [OPW-1:0] op);
    if (op == '0) return 32'h4170_0000;
    return a ^ b ^ {{(W-OPW){1'b0}}, op};
  endfunction

  logic b_window = 1'b0;
  assign a_if.fpu_result = stub(a_if.fpu_num1, a_if.fpu_num2, a_if.fpu_op);
  assign b_if.fpu_result = b_window ? stub(b_if.fpu_num1, b_if.fpu_num2, b_if.fpu_op) : '1;

  // Requester payloads for instance A.
  logic           p_v  [2] = '{1'b0, 1'b0};
  logic [W-1:0]   p_n1 [2] = '{'0, '0};
  logic [W-1:0]   p_n2 [2] = '{'0, '0};
  logic [OPW-1:0] p_op [2] = '{'0, '0};

  always_comb begin
    a_if.req0_valid = p_v[0];
    a_if.req0_num1  = p_n1[0];
    a_if.req0_num2  = p_n2[0];
    a_if.req0_op    = p_op[0];
    a_if.req1_valid = p_v[1];
    a_if.req1_num1  = p_n1[1];
    a_if.req1_num2  = p_n2[1];
    a_if.req1_op    = p_op[1];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard channels: 0/1 = instance A rsp0/rsp1, 2/3 = instance B rsp0/rsp1.
  exp_t         sb  [4][$];
  logic         vld [4];
  logic         rdy [4];
  logic         oth [4];
  logic [W-1:0] res [4];

  always_comb begin
    vld[0] = a_if.rsp0_valid; rdy[0] = a_if.rsp0_ready; oth[0] = a_if.rsp1_valid;
    vld[1] = a_if.rsp1_valid; rdy[1] = a_if.rsp1_ready; oth[1] = a_if.rsp0_valid;
    vld[2] = b_if.rsp0_valid; rdy[2] = b_if.rsp0_ready; oth[2] = b_if.rsp1_valid;
    vld[3] = b_if.rsp1_valid; rdy[3] = b_if.rsp1_ready; oth[3] = b_if.rsp0_valid;
    res[0] = a_if.rsp_result; res[1] = a_if.rsp_result;
    res[2] = b_if.rsp_result; res[3] = b_if.rsp_result;
  end

  // Monitor: pops an expectation when a response first appears, then checks it stays stable.
  initial begin
    bit   live [4] = '{0, 0, 0, 0};
    exp_t cur  [4];
    forever begin
      @(negedge clk);
      #2;
      for (int c = 0; c < 4; c++) begin
        if (rst) begin
          live[c] = 1'b0;
        end else if (vld[c]) begin
          if (!live[c]) begin
            if (sb[c].size() == 0) begin
              checks++;
              failures++;
              cur[c].res = res[c];
              $display("FAIL unexpected_rsp_ch%0d: got result 0x%08h, expected no response", c, res[c]);
            end else begin
              cur[c] = sb[c].pop_front();
              check($sformatf("rsp_cycle_ch%0d", c), 32'(cyc), 32'(cur[c].due));
              check($sformatf("rsp_result_ch%0d", c), res[c], cur[c].res);
              check($sformatf("rsp_exclusive_ch%0d", c), 32'(oth[c]), 32'd0);
            end
            live[c] = 1'b1;
          end else begin
            check($sformatf("rsp_hold_ch%0d", c), res[c], cur[c].res);
          end
          if (rdy[c]) live[c] = 1'b0;
        end else if (live[c]) begin
          check($sformatf("rsp_valid_held_ch%0d", c), 32'(vld[c]), 32'd1);
          live[c] = 1'b0;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Waits for instance A to grant; checks the grant went to exp_id. Returns the accept edge count.
  task automatic wait_accept(input int exp_id, input bit push, output int t);
    bit got = 1'b0;
    t = -1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      #1;
      if (a_if.req0_ready || a_if.req1_ready) begin
        check($sformatf("grant_req%0d", exp_id), 32'({a_if.req1_ready, a_if.req0_ready}),
              (exp_id == 0) ? 32'd1 : 32'd2);
        @(posedge clk);
        #1;
        t   = cyc;
        got = 1'b1;
        if (push) sb[exp_id].push_back('{res: stub(p_n1[exp_id], p_n2[exp_id], p_op[exp_id]),
                                         due: t + 2});
        check("owner_after_accept", 32'(a_if.owner), 32'(exp_id));
        check("busy_after_accept", 32'(a_if.busy), 32'd1);
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout_req%0d: got no ready in 40 cycles, expected a grant", exp_id);
    end
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      #1;
      done = !a_if.busy && !b_if.busy && sb[0].size() == 0 && sb[1].size() == 0 &&
             sb[2].size() == 0;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: got busy=%0d, expected idle with drained scoreboard", a_if.busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, 32'(a_if.busy), 32'd0);
    check({tag, "_owner"}, 32'(a_if.owner), 32'd0);
    check({tag, "_rsp0_valid"}, 32'(a_if.rsp0_valid), 32'd0);
    check({tag, "_rsp1_valid"}, 32'(a_if.rsp1_valid), 32'd0);
    check({tag, "_fpu_num1"}, a_if.fpu_num1, 32'd0);
    check({tag, "_fpu_num2"}, a_if.fpu_num2, 32'd0);
    check({tag, "_fpu_op"}, 32'(a_if.fpu_op), 32'd0);
    check({tag, "_rsp_result"}, a_if.rsp_result, 32'd0);
  endtask

  initial begin
    int t, t0, t1, tp;
    a_if.rsp0_ready = 1'b1;
    a_if.rsp1_ready = 1'b1;
    b_if.req0_valid = 1'b0; b_if.req0_num1 = '0; b_if.req0_num2 = '0; b_if.req0_op = '0;
    b_if.req1_valid = 1'b0; b_if.req1_num1 = '0; b_if.req1_num2 = '0; b_if.req1_op = '0;
    b_if.rsp0_ready = 1'b1;
    b_if.rsp1_ready = 1'b1;

    do_reset();
    check_zero_outputs("reset");
    check("reset_req0_ready", 32'(a_if.req0_ready), 32'd0);

    // Single operation from requester 0.
    p_v[0] = 1'b1; p_n1[0] = 32'h4120_0000; p_n2[0] = 32'h40A0_0000; p_op[0] = 4'h0;
    wait_accept(0, 1'b1, t);
    p_v[0] = 1'b0;
    check("t1_fpu_num1", a_if.fpu_num1, 32'h4120_0000);
    check("t1_fpu_num2", a_if.fpu_num2, 32'h40A0_0000);
    check("t1_fpu_op", 32'(a_if.fpu_op), 32'd0);
    wait_idle();

    // Simultaneous requests after reset: requester 0 first, requester 1 right after.
    do_reset();
    p_v[0] = 1'b1; p_n1[0] = 32'h4120_0000; p_n2[0] = 32'h40A0_0000; p_op[0] = 4'h0;
    p_v[1] = 1'b1; p_n1[1] = 32'h4040_0000; p_n2[1] = 32'h40A0_0000; p_op[1] = 4'h0;
    wait_accept(0, 1'b1, t0);
    p_v[0] = 1'b0;
    wait_accept(1, 1'b1, t1);
    p_v[1] = 1'b0;
    check("t2_spacing", 32'(t1 - t0), 32'd4);
    wait_idle();

    // Fairness: both held valid, six grants alternate starting with requester 0.
    p_v[0] = 1'b1; p_n1[0] = 32'h3F80_0000; p_n2[0] = 32'h4000_0000; p_op[0] = 4'h1;
    p_v[1] = 1'b1; p_n1[1] = 32'h4080_0000; p_n2[1] = 32'h4100_0000; p_op[1] = 4'h2;
    tp = 0;
    for (int i = 0; i < 6; i++) begin
      wait_accept(i % 2, 1'b1, t);
      if (i > 0) check($sformatf("t3_spacing_%0d", i), 32'(t - tp), 32'd4);
      tp = t;
      p_n1[i % 2] = 32'h3F80_0000 + 32'(i) * 32'h0001_1000;
      p_n2[i % 2] = 32'hC000_0000 - 32'(i) * 32'h0000_0300;
      p_op[i % 2] = 4'(i + 3);
      if (i >= 4) p_v[i % 2] = 1'b0;
    end
    wait_idle();

    // Backpressure on rsp1 while requester 0 waits.
    a_if.rsp1_ready = 1'b0;
    p_v[1] = 1'b1; p_n1[1] = 32'h4040_0000; p_n2[1] = 32'h3F00_0000; p_op[1] = 4'h5;
    wait_accept(1, 1'b1, t);
    p_v[1] = 1'b0;
    p_v[0] = 1'b1; p_n1[0] = 32'h4110_0000; p_n2[0] = 32'h4220_0000; p_op[0] = 4'h6;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("t4_req0_ready_%0d", k), 32'(a_if.req0_ready), 32'd0);
    end
    a_if.rsp1_ready = 1'b1;
    wait_accept(0, 1'b1, t0);
    p_v[0] = 1'b0;
    check("t4_accept_after_handshake", 32'(t0 - t), 32'd8);
    wait_idle();

    // Reset in the first EXEC cycle drops the operation; a fresh request then works.
    p_v[0] = 1'b1; p_n1[0] = 32'h4300_0000; p_n2[0] = 32'h4280_0000; p_op[0] = 4'h7;
    wait_accept(0, 1'b0, t);
    p_v[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero_outputs("t5");
    repeat (6) @(posedge clk);
    #1;
    p_v[0] = 1'b1; p_n1[0] = 32'h4120_0000; p_n2[0] = 32'h40A0_0000; p_op[0] = 4'h9;
    wait_accept(0, 1'b1, t);
    p_v[0] = 1'b0;
    wait_idle();

    // FPU_LAT=1 instance: result valid only during the single EXEC cycle.
    b_if.req0_valid = 1'b1;
    b_if.req0_num1  = 32'hC120_0000;
    b_if.req0_num2  = 32'hC040_0000;
    b_if.req0_op    = 4'h0;
    @(negedge clk);
    #1;
    check("t6_req0_ready", 32'(b_if.req0_ready), 32'd1);
    @(posedge clk);
    #1;
    t = cyc;
    b_if.req0_valid = 1'b0;
    sb[2].push_back('{res: stub(32'hC120_0000, 32'hC040_0000, 4'h0), due: t + 1});
    b_window = 1'b1;
    check("t6_fpu_num1", b_if.fpu_num1, 32'hC120_0000);
    check("t6_fpu_num2", b_if.fpu_num2, 32'hC040_0000);
    check("t6_rsp0_early", 32'(b_if.rsp0_valid), 32'd0);
    @(posedge clk);
    #1;
    b_window = 1'b0;
    wait_idle();

    repeat (4) @(posedge clk);
    check("sb_drained", 32'(sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
